// File: rtl/cd_host_pkg.sv
// Shared constants and types for the CD block host interface.
package cd_host_pkg;

  // Word offsets (AA[15:1]) of the host-visible registers.
  localparam logic [14:0] OFS_DTR   = 15'h0000;  // byte 0x00
  localparam logic [14:0] OFS_HIRQ  = 15'h0004;  // byte 0x08
  localparam logic [14:0] OFS_HMASK = 15'h0006;  // byte 0x0C
  localparam logic [14:0] OFS_CR1   = 15'h000C;  // byte 0x18, CR2..CR4 follow every 4 bytes

  // HIRQ bit positions.
  localparam int HIRQ_CMOK = 0;
  localparam int HIRQ_DRDY = 1;
  localparam logic [15:0] CMOK_MASK = 16'h0001;
  localparam logic [15:0] DRDY_MASK = 16'h0002;

  // Power-up response bank spells "CDBLOCK" so the BIOS sees a live drive.
  localparam logic [63:0] CRR_RESET = 64'h0043_4442_4C4F_434B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } cmd_state_e;

  // Merge host write data into a register according to the active-low byte strobes.
  function automatic logic [15:0] lane_merge(input logic [15:0] cur, input logic [15:0] din,
                                             input logic wru_n, input logic wrl_n);
    logic [15:0] r;
    r = cur;
    if (!wru_n) r[15:8] = din[15:8];
    if (!wrl_n) r[7:0]  = din[7:0];
    return r;
  endfunction

endpackage

// File: rtl/cd_host_fifo.sv
// Show-ahead data-transfer FIFO: head word is visible before it is popped.
module cd_host_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ce_i,
  input  logic                          push_i,
  input  logic [15:0]                   push_data_i,
  input  logic                          pop_i,
  output logic [15:0]                   head_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign do_push = ce_i & push_i & ~full_o;
  assign do_pop  = ce_i & pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cd_host_if.sv
// CD block host interface: A-bus register file, command handshake to the drive
// model and the sector data FIFO read through DTR.
module cd_host_if
  import cd_host_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int WAIT_MAX   = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CS_N,
  input  logic [14:0] A,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  input  logic        RD_N,
  input  logic        WRU_N,
  input  logic        WRL_N,
  output logic        WAIT_N,
  output logic        IRQ_N,
  output logic        CMD_VALID,
  output logic [63:0] CMD,
  input  logic        CMD_READY,
  input  logic        RSP_VALID,
  input  logic [63:0] RSP,
  input  logic [15:0] RSP_HIRQ,
  output logic        RSP_READY,
  input  logic [15:0] STAT_HIRQ,
  input  logic        DATA_WR,
  input  logic [15:0] DATA_IN,
  output logic        DATA_FULL
);
  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  // Access detection: side effects fire once, on the first cycle of an access.
  logic acc, acc_new, acc_start, wr_start, rd_start, prev_acc_q;
  logic hit_dtr, hit_hirq, hit_hmask;
  logic [3:0] cr_hit;

  logic [15:0] hirq_q, hirq_d, hirq_set;
  logic [15:0] hmask_q, hmask_d;
  logic [15:0] crw_q [4];
  logic [15:0] crw_d [4];
  logic [63:0] crr_q, cmd_q, cmd_d;
  cmd_state_e  state_q, state_d;
  logic        launch, cmd_acc, rsp_done, drdy_set;
  logic        irq_n_q;

  logic        wait_q;
  logic [7:0]  wait_cnt_q;
  logic        wait_hold, fifo_pop;

  logic [15:0] fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic        fifo_full, fifo_empty;

  assign acc       = ~CS_N & (~RD_N | ~WRU_N | ~WRL_N);
  assign acc_new   = acc & ~prev_acc_q;
  assign acc_start = CE_R & acc_new;
  assign wr_start  = acc_start & (~WRU_N | ~WRL_N);
  assign rd_start  = acc_start & ~RD_N;
  assign hit_dtr   = (A == OFS_DTR);
  assign hit_hirq  = (A == OFS_HIRQ);
  assign hit_hmask = (A == OFS_HMASK);

  // CR write bank decode and byte-lane merge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cr
    assign cr_hit[gi] = (A == OFS_CR1 + 15'(2 * gi));
    assign crw_d[gi]  = (wr_start && cr_hit[gi]) ? lane_merge(crw_q[gi], DI, WRU_N, WRL_N)
                                                 : crw_q[gi];
  end

  // A CR4 write launches a command only when the previous one has completed (CMOK).
  assign launch   = wr_start & cr_hit[3] & (state_q == ST_IDLE) & hirq_q[HIRQ_CMOK];
  assign cmd_acc  = CE_R & (state_q == ST_ISSUE) & CMD_READY;
  assign rsp_done = CE_R & (state_q == ST_RESP) & RSP_VALID;
  assign cmd_d    = launch ? {crw_d[0], crw_d[1], crw_d[2], crw_d[3]} : cmd_q;
  assign hmask_d  = (wr_start && hit_hmask) ? lane_merge(hmask_q, DI, WRU_N, WRL_N) : hmask_q;

  // DRDY marks the FIFO going from empty to holding a word.
  assign drdy_set = DATA_WR & (fifo_count == '0);
  assign hirq_set = STAT_HIRQ | (rsp_done ? (CMOK_MASK | RSP_HIRQ) : 16'h0000)
                  | (drdy_set ? DRDY_MASK : 16'h0000);

  // HIRQ next state: host write-0-to-clear, launch clears CMOK, then sets override clears.
  always_comb begin
    hirq_d = hirq_q;
    if (wr_start && hit_hirq) begin
      if (!WRU_N) hirq_d[15:8] = hirq_q[15:8] & DI[15:8];
      if (!WRL_N) hirq_d[7:0]  = hirq_q[7:0] & DI[7:0];
    end
    if (launch) hirq_d[HIRQ_CMOK] = 1'b0;
    hirq_d = hirq_d | hirq_set;
  end

  // Command FSM next state: one transition per enabled cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (launch)   state_d = ST_ISSUE;
      ST_ISSUE: if (cmd_acc)  state_d = ST_RESP;
      ST_RESP:  if (rsp_done) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Register file, command snapshot, response bank and interrupt output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_acc_q <= 1'b0;
      hirq_q     <= CMOK_MASK;
      hmask_q    <= 16'hFFFF;
      crr_q      <= CRR_RESET;
      cmd_q      <= '0;
      state_q    <= ST_IDLE;
      irq_n_q    <= 1'b0;
      for (int i = 0; i < 4; i++) crw_q[i] <= '0;
    end else if (CE_R) begin
      prev_acc_q <= acc;
      hirq_q     <= hirq_d;
      hmask_q    <= hmask_d;
      cmd_q      <= cmd_d;
      state_q    <= state_d;
      irq_n_q    <= ~|(hirq_q & hmask_q);
      if (rsp_done) crr_q <= RSP;
      for (int i = 0; i < 4; i++) crw_q[i] <= crw_d[i];
    end
  end

  // DTR wait tracking: armed by a read of an empty FIFO, ends on data, timeout or host release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else if (CE_R) begin
      if (rd_start && hit_dtr && fifo_empty) begin
        wait_q     <= 1'b1;
        wait_cnt_q <= 8'd1;
      end else if (wait_q) begin
        if (!acc || !fifo_empty || wait_cnt_q >= WAIT_LIMIT) wait_q <= 1'b0;
        else if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

  // The start cycle of an empty DTR read already stalls the bus, so the hold is combinational.
  assign wait_hold = fifo_empty & ((acc_new & ~RD_N & hit_dtr)
                                   | (wait_q & acc & (wait_cnt_q < WAIT_LIMIT)));
  assign WAIT_N    = ~(wait_hold & ~RST);
  assign fifo_pop  = (rd_start & hit_dtr & ~fifo_empty) | (wait_q & acc & ~fifo_empty);

  cd_host_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .ce_i        (CE_R),
    .push_i      (DATA_WR),
    .push_data_i (DATA_IN),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Read mux: only drives the bus during a selected read.
  always_comb begin
    DO = 16'h0000;
    if (!CS_N && !RD_N) begin
      case (A)
        OFS_DTR:            DO = fifo_empty ? 16'h0000 : fifo_head;
        OFS_HIRQ:           DO = hirq_q;
        OFS_HMASK:          DO = hmask_q;
        OFS_CR1:            DO = crr_q[63:48];
        OFS_CR1 + 15'd2:    DO = crr_q[47:32];
        OFS_CR1 + 15'd4:    DO = crr_q[31:16];
        OFS_CR1 + 15'd6:    DO = crr_q[15:0];
        default:            DO = 16'h0000;
      endcase
    end
  end

  assign IRQ_N     = irq_n_q;
  assign CMD       = cmd_q;
  assign CMD_VALID = (state_q == ST_ISSUE) & ~RST;
  assign RSP_READY = (state_q == ST_RESP) & ~RST;
  assign DATA_FULL = fifo_full;

endmodule

// File: tb/tb_cd_host_if.sv
// Scoreboarded bench for cd_host_if: host reads push expected data, a negedge
// monitor compares DO when the bus is not waited; an op-level model tracks state.
module tb_cd_host_if;
  logic        CLK = 1'b0;
  logic        RST, CE_R, CS_N, RD_N, WRU_N, WRL_N, WAIT_N, IRQ_N;
  logic [14:0] A;
  logic [15:0] DI, DO, RSP_HIRQ, STAT_HIRQ, DATA_IN;
  logic        CMD_VALID, CMD_READY, RSP_VALID, RSP_READY, DATA_WR, DATA_FULL;
  logic [63:0] CMD, RSP;

  always #5 CLK = ~CLK;

  cd_host_if #(.FIFO_DEPTH(16), .WAIT_MAX(255)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CS_N(CS_N), .A(A), .DI(DI), .DO(DO),
    .RD_N(RD_N), .WRU_N(WRU_N), .WRL_N(WRL_N), .WAIT_N(WAIT_N), .IRQ_N(IRQ_N),
    .CMD_VALID(CMD_VALID), .CMD(CMD), .CMD_READY(CMD_READY), .RSP_VALID(RSP_VALID),
    .RSP(RSP), .RSP_HIRQ(RSP_HIRQ), .RSP_READY(RSP_READY), .STAT_HIRQ(STAT_HIRQ),
    .DATA_WR(DATA_WR), .DATA_IN(DATA_IN), .DATA_FULL(DATA_FULL)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [15:0] ofs; logic [15:0] val; } exp_t;
  exp_t exp_q[$];

  // Reference model of the host-visible state.
  logic [15:0] m_hirq, m_mask;
  logic [15:0] m_crw [4];
  logic [15:0] m_crr [4];
  logic [15:0] m_fifo[$];
  int          m_pend;   // 0 none, 1 waiting for drive accept, 2 waiting for response
  logic [63:0] m_cmd;

  logic rd_active = 1'b0;
  logic rd_done = 1'b0;
  int   wait_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s = %h", name, act);
  endtask

  // Monitor: compare DO on the first unwaited cycle of each host read.
  always @(negedge CLK) begin
    exp_t e;
    if (rd_active && !rd_done) begin
      if (WAIT_N) begin
        rd_done = 1'b1;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rd_unexpected: got %h expected none", DO);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("read@%h", e.ofs), 64'(DO), 64'(e.val));
        end
      end else
        wait_cycles++;
    end
  end

  function automatic void m_reset();
    m_hirq = 16'h0001; m_mask = 16'hFFFF;
    m_crr[0] = 16'h0043; m_crr[1] = 16'h4442; m_crr[2] = 16'h4C4F; m_crr[3] = 16'h434B;
    for (int i = 0; i < 4; i++) m_crw[i] = 16'h0000;
    m_fifo.delete(); m_pend = 0; m_cmd = '0;
  endfunction

  function automatic void m_write(input logic [15:0] ofs, input logic [15:0] d,
                                  input logic [1:0] lanes, input logic [15:0] stat);
    logic [15:0] keep;
    int idx;
    keep = {{8{~lanes[1]}}, {8{~lanes[0]}}};
    case (ofs)
      16'h0008: m_hirq = m_hirq & (d | keep);
      16'h000C: m_mask = (m_mask & keep) | (d & ~keep);
      16'h0018, 16'h001C, 16'h0020, 16'h0024: begin
        idx = int'(ofs - 16'h0018) / 4;
        m_crw[idx] = (m_crw[idx] & keep) | (d & ~keep);
        if (idx == 3 && m_pend == 0 && m_hirq[0]) begin
          m_hirq[0] = 1'b0; m_pend = 1;
          m_cmd = {m_crw[0], m_crw[1], m_crw[2], m_crw[3]};
        end
      end
      default: ;
    endcase
    m_hirq = m_hirq | stat;
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] ofs);
    case (ofs)
      16'h0000: return (m_fifo.size() > 0) ? m_fifo.pop_front() : 16'h0000;
      16'h0008: return m_hirq;
      16'h000C: return m_mask;
      16'h0018: return m_crr[0];
      16'h001C: return m_crr[1];
      16'h0020: return m_crr[2];
      16'h0024: return m_crr[3];
      default:  return 16'h0000;
    endcase
  endfunction

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic bus_write(input logic [15:0] ofs, input logic [15:0] d,
                           input logic [1:0] lanes, input logic [15:0] stat);
    CS_N = 1'b0; A = ofs[15:1]; DI = d; WRU_N = ~lanes[1]; WRL_N = ~lanes[0]; STAT_HIRQ = stat;
    @(posedge CLK); #1;
    CS_N = 1'b1; WRU_N = 1'b1; WRL_N = 1'b1; STAT_HIRQ = 16'h0000;
    m_write(ofs, d, lanes, stat);
    idle(1);
  endtask

  task automatic do_read(input logic [15:0] ofs);
    int n;
    n = 0;
    wait_cycles = 0; rd_done = 1'b0; rd_active = 1'b1;
    CS_N = 1'b0; A = ofs[15:1]; RD_N = 1'b0;
    while (!rd_done && n < 400) begin @(posedge CLK); n++; end
    #1; CS_N = 1'b1; RD_N = 1'b1; rd_active = 1'b0;
    if (!rd_done) begin
      vectors++; miscompares++;
      $display("FAIL rd_timeout: got WAIT_N=%b expected 1 within 400 cycles", WAIT_N);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    idle(1);
  endtask

  task automatic bus_read(input logic [15:0] ofs);
    exp_t e;
    e.ofs = ofs; e.val = m_read(ofs);
    exp_q.push_back(e);
    do_read(ofs);
  endtask

  task automatic raw_push(input logic [15:0] w);
    DATA_WR = 1'b1; DATA_IN = w;
    @(posedge CLK); #1;
    DATA_WR = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    raw_push(w);
    if (m_fifo.size() < 16) begin
      if (m_fifo.size() == 0) m_hirq = m_hirq | 16'h0002;
      m_fifo.push_back(w);
    end
    idle(1);
  endtask

  task automatic stat_pulse(input logic [15:0] s);
    STAT_HIRQ = s; @(posedge CLK); #1; STAT_HIRQ = 16'h0000;
    m_hirq = m_hirq | s;
    idle(1);
  endtask

  task automatic cmd_accept();
    check("cmd_valid", 64'(CMD_VALID), 64'd1);
    check("cmd_word", CMD, m_cmd);
    CMD_READY = 1'b1; @(posedge CLK); #1; CMD_READY = 1'b0;
    m_pend = 2;
    check("rsp_ready", 64'(RSP_READY), 64'd1);
    idle(1);
  endtask

  task automatic rsp_deliver(input logic [63:0] r, input logic [15:0] h);
    RSP_VALID = 1'b1; RSP = r; RSP_HIRQ = h;
    @(posedge CLK); #1; RSP_VALID = 1'b0;
    m_crr[0] = r[63:48]; m_crr[1] = r[47:32]; m_crr[2] = r[31:16]; m_crr[3] = r[15:0];
    m_hirq = m_hirq | 16'h0001 | h; m_pend = 0;
    idle(1);
  endtask

  task automatic status_check();
    check("irq_n", 64'(IRQ_N), 64'(~|(m_hirq & m_mask)));
    check("data_full", 64'(DATA_FULL), 64'(m_fifo.size() == 16));
    check("cmd_pending", 64'(CMD_VALID), 64'(m_pend == 1));
  endtask

  function automatic logic [15:0] pick_ofs();
    logic [15:0] tbl [9];
    tbl = '{16'h0000, 16'h0008, 16'h000C, 16'h0018, 16'h001C, 16'h0020, 16'h0024, 16'h0010, 16'h003E};
    return tbl[$urandom_range(0, 8)];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [15:0] ofs;
    RST = 1'b1; CE_R = 1'b1; CS_N = 1'b1; A = '0; DI = '0; RD_N = 1'b1; WRU_N = 1'b1; WRL_N = 1'b1;
    CMD_READY = 1'b0; RSP_VALID = 1'b0; RSP = '0; RSP_HIRQ = '0; STAT_HIRQ = '0;
    DATA_WR = 1'b0; DATA_IN = '0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;

    // Reset state
    check("rst_irq_n", 64'(IRQ_N), 64'd0);
    check("rst_wait_n", 64'(WAIT_N), 64'd1);
    check("rst_cmd_valid", 64'(CMD_VALID), 64'd0);
    check("rst_rsp_ready", 64'(RSP_READY), 64'd0);
    check("rst_data_full", 64'(DATA_FULL), 64'd0);
    bus_read(16'h0018); bus_read(16'h001C); bus_read(16'h0020); bus_read(16'h0024);
    bus_read(16'h0008);

    // Command launch and response
    bus_write(16'h0018, 16'h1000, 2'b11, 16'h0);
    bus_write(16'h001C, 16'h0000, 2'b11, 16'h0);
    bus_write(16'h0020, 16'h0000, 2'b11, 16'h0);
    bus_write(16'h0024, 16'h0000, 2'b11, 16'h0);
    check("launch_cmd", CMD, 64'h1000_0000_0000_0000);
    bus_read(16'h0008);
    cmd_accept();
    rsp_deliver(64'h2000_0001_0002_0003, 16'h0040);
    bus_read(16'h0018);
    bus_read(16'h0008);

    // HIRQ clear, and clear colliding with a status set
    stat_pulse(16'h0080);
    bus_write(16'h0008, 16'hFF7E, 2'b11, 16'h0000);
    bus_read(16'h0008);
    stat_pulse(16'h0081);
    bus_write(16'h0008, 16'hFF7E, 2'b11, 16'h0001);
    bus_read(16'h0008);

    // FIFO reads, then a waited read satisfied by a late push
    push_word(16'hAAAA); push_word(16'h5555);
    bus_read(16'h0000); bus_read(16'h0000);
    e.ofs = 16'h0000; e.val = 16'h1234; exp_q.push_back(e);
    fork
      do_read(16'h0000);
      begin repeat (10) @(posedge CLK); #1; raw_push(16'h1234); end
    join
    m_hirq = m_hirq | 16'h0002;
    check("wait_until_push", 64'(wait_cycles), 64'd11);

    // Waited read that times out
    bus_read(16'h0000);
    check("wait_timeout_len", 64'(wait_cycles), 64'd255);

    // Overfill: 17 pushes at depth 16
    for (int i = 0; i < 17; i++) begin
      push_word(16'($urandom));
      if (i == 15) check("full_at_16", 64'(DATA_FULL), 64'd1);
    end
    check("full_after_17", 64'(DATA_FULL), 64'd1);
    for (int i = 0; i < 16; i++) bus_read(16'h0000);
    status_check();

    // Randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      int op;
      op = int'($urandom_range(0, 6));
      case (op)
        0, 1: bus_write(pick_ofs(), 16'($urandom), 2'($urandom_range(1, 3)), 16'h0000);
        2: begin
          ofs = pick_ofs();
          if (ofs == 16'h0000 && m_fifo.size() == 0) ofs = 16'h0008;
          bus_read(ofs);
        end
        3: push_word(16'($urandom));
        4: stat_pulse(16'(1 << $urandom_range(0, 15)));
        5: begin
          if (m_pend == 1) cmd_accept();
          else if (m_pend == 2) rsp_deliver({$urandom, $urandom}, 16'(1 << $urandom_range(2, 15)));
          else begin
            if (!m_hirq[0]) stat_pulse(16'h0001);
            bus_write(16'h0024, 16'($urandom), 2'b11, 16'h0000);
          end
        end
        default: status_check();
      endcase
    end
    status_check();

    // Interrupt mask: IRQ_N follows one cycle after the mask write
    bus_write(16'h000C, 16'hFFFF, 2'b11, 16'h0000);
    stat_pulse(16'h0001);
    check("irq_asserted", 64'(IRQ_N), 64'd0);
    CS_N = 1'b0; A = 15'h0006; DI = 16'h0000; WRU_N = 1'b0; WRL_N = 1'b0;
    @(posedge CLK); #1;
    CS_N = 1'b1; WRU_N = 1'b1; WRL_N = 1'b1; m_mask = 16'h0000;
    check("irq_same_cycle", 64'(IRQ_N), 64'd0);
    @(posedge CLK); #1;
    check("irq_masked", 64'(IRQ_N), 64'd1);
    idle(1);

    // Reset during ISSUE
    if (m_pend == 1) cmd_accept();
    if (m_pend == 2) rsp_deliver(64'h0, 16'h0);
    stat_pulse(16'h0001);
    bus_write(16'h0024, 16'h00AA, 2'b11, 16'h0000);
    check("issue_before_rst", 64'(CMD_VALID), 64'd1);
    RST = 1'b1; #1;
    check("rst_drops_cmd_valid", 64'(CMD_VALID), 64'd0);
    @(posedge CLK); #1; RST = 1'b0;
    m_reset();
    bus_read(16'h0008);
    bus_read(16'h0018);
    check("post_rst_cmd_valid", 64'(CMD_VALID), 64'd0);

    // Reset during a DTR wait releases WAIT_N on the reset cycle
    e.ofs = 16'h0000; e.val = 16'h0000; exp_q.push_back(e);
    fork
      do_read(16'h0000);
      begin repeat (5) @(posedge CLK); #1; RST = 1'b1; @(posedge CLK); #1; RST = 1'b0; end
    join
    m_reset();
    check("rst_wait_len", 64'(wait_cycles), 64'd5);
    bus_read(16'h0008);
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cd_host_if.md
Name: cd_host_if

Overview:
- A-bus responder for the CD block host interface: register file, command handshake and data-transfer FIFO, all behind the SCU A-bus CS2 window at 0x2589xxxx.
- Replaces the fixed-value HIRQ/HIRQMASK/CR1-4 stub in the Saturn top level.
- On the drive side, it presents a command/response handshake and a word-push data port to the CD drive model.

Parameters:
- FIFO_DEPTH, 16, data-transfer FIFO depth in 16-bit words (power of 2).
- WAIT_MAX, 255, maximum CE_R cycles WAIT_N is held low on a DTR read of an empty FIFO.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- CE_R  in  1  clock enable; all state advances only when CE_R=1.
- CS_N  in  1  window select, low when ACS2_N=0 and AA[25:16]=0x189 (decoded outside this block).
- A  in  15  AA[15:1] word offset.
- DI  in  16  write data from SCU.
- DO  out  16  read data to SCU (ADI).
- RD_N  in  1  read strobe.
- WRU_N  in  1  upper-byte write strobe.
- WRL_N  in  1  lower-byte write strobe.
- WAIT_N  out  1  A-bus wait.
- IRQ_N  out  1  CD interrupt to SCU.
- CMD_VALID  out  1  command pending to drive.
- CMD  out  64  {CR1,CR2,CR3,CR4} as written by host.
- CMD_READY  in  1  drive accepts command.
- RSP_VALID  in  1  drive response valid.
- RSP  in  64  {CR1..CR4} response words.
- RSP_HIRQ  in  16  extra HIRQ bits to set with the response.
- RSP_READY  out  1  block accepts response.
- STAT_HIRQ  in  16  per-cycle HIRQ set pulses (async status events).
- DATA_WR  in  1  push DATA_IN into FIFO.
- DATA_IN  in  16  sector data word.
- DATA_FULL  out  1  FIFO full.

Behaviour:
- Register map (byte offset {A,0}):
  - 0x00 DTR: read pops FIFO.
  - 0x08 HIRQ.
  - 0x0C HIRQMASK.
  - 0x18/0x1C/0x20/0x24: CR1-4.
  - Other offsets read 0x0000; writes to them are ignored.
- Access start: CE_R cycle where CS_N=0 and any strobe is low, and the previous CE_R cycle had no access. All side effects (pop, write, command launch) happen once per access, on the start cycle, regardless of strobe length.
- Byte lanes: WRU_N=0 writes [15:8], WRL_N=0 writes [7:0].
- CR writes go to CRW[0..3]. CR reads return CRR[0..3]; the two banks are separate.
- HIRQ write: HIRQ <= HIRQ & DI per enabled lane (write-0-to-clear).
- HIRQ set sources OR in each CE_R cycle: STAT_HIRQ, and response completion. When a set and a host clear hit the same bit in the same cycle, set wins.
- HIRQ bit 0 is CMOK; bit 1 is DRDY.
- Command FSM:
  - IDLE: a CR4 write while HIRQ.CMOK=1 clears CMOK and goes to ISSUE. A CR4 write with CMOK=0 updates CRW only, with no launch.
  - ISSUE: CMD_VALID=1 with CMD=CRW snapshot taken at the launch cycle. On CMD_READY, go to RESP.
  - RESP: RSP_READY=1. On RSP_VALID: CRR<=RSP, HIRQ |= 0x0001|RSP_HIRQ, return to IDLE.
  - Each transition takes one CE_R cycle.
- FIFO:
  - DATA_WR while full: word dropped, no state change.
  - Simultaneous push and pop: both occur; count unchanged.
  - DRDY is set on the cycle the count goes 0->1.
- DTR read:
  - Non-empty: DO=head word (show-ahead); pop on access start; WAIT_N=1.
  - Empty: WAIT_N=0 from access start until a word arrives (then DO=word, pop, WAIT_N=1) or WAIT_MAX cycles elapse (then DO=0x0000, no pop, WAIT_N=1).
  - The wait counter is 8-bit and saturates.
- DO: combinational from the selected register when CS_N=0 and RD_N=0; otherwise 0x0000.
- IRQ_N: registered ~|(HIRQ & HIRQMASK), updates one CE_R cycle after HIRQ/HIRQMASK change.
- Reset values:
  - HIRQ=0x0001.
  - HIRQMASK=0xFFFF.
  - CRR={0x0043,0x4442,0x4C4F,0x434B} ("CDBLOCK").
  - CRW=0.
  - FIFO empty.
  - FSM IDLE.
  - WAIT_N=1, IRQ_N=0, CMD_VALID=0, RSP_READY=0, DATA_FULL=0.
- RST asserted mid-command or mid-wait drops all pending state immediately. WAIT_N is released and CMD_VALID deasserted on the reset cycle.

Decomposition:
- Package cd_host_pkg holds:
  - register offset localparams;
  - HIRQ bit indices (CMOK=0, DRDY=1);
  - CRR reset signature;
  - FSM state enum (IDLE, ISSUE, RESP).
- Sub-module cd_host_fifo: synchronous show-ahead FIFO with push/pop/count/full/empty, parameter FIFO_DEPTH.

Test Plan:
- Reset, then read 0x18/0x1C/0x20/0x24/0x08 -> 0x0043, 0x4442, 0x4C4F, 0x434B, 0x0001. IRQ_N=0.
- Write CR1-4=0x1000,0,0,0 -> CMD_VALID=1, CMD=0x1000_0000_0000_0000, HIRQ.CMOK=0.
  - Then CMD_READY, then RSP_VALID with RSP=0x2000_0001_0002_0003, RSP_HIRQ=0x0040 -> CR1 reads 0x2000, HIRQ=0x0041.
- With HIRQ=0x00C1, write 0x08 DI=0xFF7E (both lanes) -> HIRQ=0x0040. Same write in a cycle with STAT_HIRQ=0x0001 -> HIRQ=0x0041.
- Push 0xAAAA, 0x5555, then two DTR reads -> 0xAAAA, 0x5555. Third read with empty FIFO -> WAIT_N=0; push 0x1234 after 10 cycles -> WAIT_N=1, DO=0x1234.
- Empty-FIFO DTR read with no push -> WAIT_N low for exactly 255 CE_R cycles, DO=0x0000. Push 17 words at depth 16 -> DATA_FULL=1, 17th dropped.
- HIRQMASK=0x0000 -> IRQ_N=1 one cycle later. Assert RST during ISSUE -> CMD_VALID=0, HIRQ=0x0001 next cycle.
